// File: rtl/ram_loader_pkg.sv
// Shared definitions for the program/data RAM loader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the loader state encoding and the RAM geometry that the loader and
// the 256x8 RAM both build against.
package ram_loader_pkg;

  // RAM geometry shared with the RAM itself.
  localparam int RAM_ADDR_WIDTH = 8;
  localparam int RAM_DATA_WIDTH = 8;
  localparam int RAM_DEPTH      = 1 << RAM_ADDR_WIDTH;

  // Loader sequencing: accept bytes, read them back, report once.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_VERIFY = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/loader_addr_counter.sv
// Wrapping RAM pointer plus remaining-item counter for the loader.
// Latency: load/step take effect on the next rising edge; 'last' is combinational.
// Backpressure: none; advances only when 'enable' is high, 'load' has priority.
//
// Ports:
//   clk, reset       - clock, async active-high reset
//   load             - reload pointer from load_ptr and counter from load_count
//   load_ptr         - pointer reload value (base address)
//   load_count       - counter reload value (0..2^ADDR_WIDTH)
//   enable           - step: pointer += 1 (wraps), remaining -= 1
//   ptr, remaining   - current pointer and items still to go
//   last             - the current item is the final one (remaining == 1)
module loader_addr_counter
  import ram_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = RAM_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] load_ptr,
  input  logic [ADDR_WIDTH:0]   load_count,
  input  logic                  enable,
  output logic [ADDR_WIDTH-1:0] ptr,
  output logic [ADDR_WIDTH:0]   remaining,
  output logic                  last
);

  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = 1;
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = 1;

  // The counter is one bit wider than the pointer so a full-RAM run
  // (2^ADDR_WIDTH items) is representable; the pointer simply wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr       <= '0;
      remaining <= '0;
    end else if (load) begin
      ptr       <= load_ptr;
      remaining <= load_count;
    end else if (enable) begin
      ptr       <= ptr + PTR_ONE;
      remaining <= remaining - CNT_ONE;
    end
  end

  assign last = (remaining == CNT_ONE);

endmodule

// File: rtl/ram_loader.sv
// RAM loader: streams bytes into consecutive RAM addresses, reads them back, checks an 8-bit sum.
// Latency: N-byte run with no stalls gives done at T+2N+1 after the start cycle T; length 0 gives done at T+1.
// Backpressure: inReady is high for the whole LOAD phase; inValid low stalls LOAD one cycle with no write.
//
// Ports:
//   clk, reset        - clock, async active-high reset
//   start             - begin a run (only honoured in IDLE)
//   baseAddr, length  - region start and byte count (0..256), captured with start
//   inValid/inReady   - byte-stream handshake, inData is the byte
//   ramAddr, ramDataIn, ramWriteEnable, ramReadEnable, ramDataOut - RAM pins
//   busy              - loader owns the RAM (LOAD, VERIFY, DONE)
//   done              - one-cycle end-of-run pulse
//   verifyOk          - sticky result of the last run
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = RAM_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] baseAddr,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic                  inValid,
  input  logic [DATA_WIDTH-1:0] inData,
  output logic                  inReady,
  output logic [ADDR_WIDTH-1:0] ramAddr,
  output logic [DATA_WIDTH-1:0] ramDataIn,
  output logic                  ramWriteEnable,
  output logic                  ramReadEnable,
  input  logic [DATA_WIDTH-1:0] ramDataOut,
  output logic                  busy,
  output logic                  done,
  output logic                  verifyOk
);

  state_t state, state_nxt;

  // Run parameters kept for the reload between LOAD and VERIFY.
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH:0]   len_q;

  logic [DATA_WIDTH-1:0] wsum;
  logic [DATA_WIDTH-1:0] rsum;
  logic [DATA_WIDTH-1:0] rsum_nxt;
  logic                  ok_q;

  logic                  cnt_load;
  logic [ADDR_WIDTH-1:0] cnt_load_ptr;
  logic [ADDR_WIDTH:0]   cnt_load_count;
  logic                  cnt_en;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [ADDR_WIDTH:0]   remaining;
  logic                  last;

  logic start_ok;
  logic xfer;

  assign start_ok = (state == ST_IDLE) && start;
  assign xfer     = (state == ST_LOAD) && inValid;
  assign rsum_nxt = rsum + ramDataOut;

  loader_addr_counter #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_cnt (
    .clk       (clk),
    .reset     (reset),
    .load      (cnt_load),
    .load_ptr  (cnt_load_ptr),
    .load_count(cnt_load_count),
    .enable    (cnt_en),
    .ptr       (ptr),
    .remaining (remaining),
    .last      (last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, counter control and RAM-side outputs. The write strobe and
  // data are combinational from the handshake so the RAM captures the byte
  // on the same edge the transfer completes.
  always_comb begin
    state_nxt      = state;
    cnt_load       = 1'b0;
    cnt_load_ptr   = baseAddr;
    cnt_load_count = length;
    cnt_en         = 1'b0;
    inReady        = 1'b0;
    ramWriteEnable = 1'b0;
    ramReadEnable  = 1'b0;
    ramAddr        = '0;
    ramDataIn      = '0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          cnt_load  = 1'b1;
          state_nxt = (length == '0) ? ST_DONE : ST_LOAD;
        end
      end

      ST_LOAD: begin
        inReady        = 1'b1;
        ramWriteEnable = inValid;
        ramDataIn      = inData;
        ramAddr        = ptr;
        if (inValid) begin
          if (last) begin
            // Rewind to the region start for the read-back pass.
            cnt_load       = 1'b1;
            cnt_load_ptr   = base_q;
            cnt_load_count = len_q;
            state_nxt      = ST_VERIFY;
          end else begin
            cnt_en = 1'b1;
          end
        end
      end

      ST_VERIFY: begin
        ramReadEnable = 1'b1;
        ramAddr       = ptr;
        cnt_en        = 1'b1;
        if (last) begin
          state_nxt = ST_DONE;
        end
      end

      ST_DONE: begin
        state_nxt = ST_IDLE;
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Checksums, captured run parameters and the sticky result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_q <= '0;
      len_q  <= '0;
      wsum   <= '0;
      rsum   <= '0;
      ok_q   <= 1'b0;
    end else begin
      if (start_ok) begin
        base_q <= baseAddr;
        len_q  <= length;
        wsum   <= '0;
        rsum   <= '0;
        // An empty run has nothing to disagree about.
        ok_q   <= (length == '0);
      end else if (xfer) begin
        wsum <= wsum + inData;
      end else if (state == ST_VERIFY) begin
        rsum <= rsum_nxt;
        // Result is latched on the edge into DONE (using the final read
        // folded in) so it is already valid while done is high.
        if (last) begin
          ok_q <= (wsum == rsum_nxt);
        end
      end
    end
  end

  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);
  assign verifyOk = ok_q;

endmodule

// File: tb/tb_ram_loader.sv
// Self-checking bench for ram_loader with a behavioural RAM and a timeline model.
// Latency: n/a (bench).
// Backpressure: drives inValid with random stall gaps.
module tb_ram_loader;
  import ram_loader_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] baseAddr;
  logic [8:0] length;
  logic       inValid;
  logic [7:0] inData;
  logic       inReady;
  logic [7:0] ramAddr;
  logic [7:0] ramDataIn;
  logic       ramWriteEnable;
  logic       ramReadEnable;
  logic [7:0] ramDataOut;
  logic       busy;
  logic       done;
  logic       verifyOk;

  always #5 clk = ~clk;

  ram_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .baseAddr      (baseAddr),
    .length        (length),
    .inValid       (inValid),
    .inData        (inData),
    .inReady       (inReady),
    .ramAddr       (ramAddr),
    .ramDataIn     (ramDataIn),
    .ramWriteEnable(ramWriteEnable),
    .ramReadEnable (ramReadEnable),
    .ramDataOut    (ramDataOut),
    .busy          (busy),
    .done          (done),
    .verifyOk      (verifyOk)
  );

  // Behavioural 256x8 RAM, combinational read, with an optional one-shot
  // corruption of address 0x11 at the end of the first read-back cycle.
  logic [7:0] ram [0:RAM_DEPTH-1];
  bit corrupt_req = 1'b0;
  bit flipped = 1'b0;
  assign ramDataOut = ram[ramAddr];
  always @(posedge clk) begin
    if (ramWriteEnable) ram[ramAddr] <= ramDataIn;
    if (!corrupt_req) flipped <= 1'b0;
    else if (ramReadEnable && !flipped) begin
      ram[8'h11] <= ram[8'h11] ^ 8'h01;
      flipped <= 1'b1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Timeline model of the current run.
  int         t_start, n_cur, load_end, done_cyc;
  logic [7:0] base_cur;
  bit         exp_ok = 1'b0, prev_ok = 1'b0;
  bit         have_run = 1'b0, in_reset = 1'b0;
  int         wr_cnt = 0, wr_seen = 0, done_seen = -1;

  logic [7:0] dat [0:255];
  int         stl [0:255];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=0x%0h expected=0x%0h", name, cyc, act, exp);
    end
  endtask

  // Per-cycle comparison of every output against the model timeline.
  task automatic cycle_check();
    bit active, in_load, in_ver, busy_e, done_e, ok_e, we_e;
    active  = have_run && !in_reset;
    in_load = active && cyc > t_start && cyc <= load_end;
    in_ver  = active && cyc > load_end && cyc <= load_end + n_cur;
    busy_e  = active && cyc > t_start && cyc <= done_cyc;
    done_e  = active && cyc == done_cyc;
    ok_e    = !active ? 1'b0 : (cyc <= t_start) ? prev_ok : (cyc >= done_cyc) ? exp_ok : 1'b0;
    we_e    = in_load && inValid;
    if (ramWriteEnable) wr_seen++;
    if (done) done_seen = cyc;
    chk("inReady", int'(inReady), int'(in_load));
    chk("writeEnable", int'(ramWriteEnable), int'(we_e));
    chk("readEnable", int'(ramReadEnable), int'(in_ver));
    chk("busy", int'(busy), int'(busy_e));
    chk("done", int'(done), int'(done_e));
    chk("verifyOk", int'(verifyOk), int'(ok_e));
    if (we_e) begin
      chk("writeAddr", int'(ramAddr), (int'(base_cur) + wr_cnt) % 256);
      chk("writeData", int'(ramDataIn), int'(inData));
      wr_cnt++;
    end
    if (in_ver) chk("readAddr", int'(ramAddr), (int'(base_cur) + cyc - load_end - 1) % 256);
    if (!busy_e) begin
      chk("idleAddr", int'(ramAddr), 0);
      chk("idleDataIn", int'(ramDataIn), 0);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cycle_check();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] stored(input logic [7:0] b, input int i, input bit corrupt);
    logic [7:0] v;
    v = dat[i];
    // The flip lands after the first read, so it only counts past item 0.
    if (corrupt && i > 0 && ((int'(b) + i) % 256) == 17) v = v ^ 8'h01;
    return v;
  endfunction

  task automatic do_run(input logic [7:0] b, input int n, input bit corrupt,
                        input int abort_at, input bit spur);
    int stall_total = 0;
    int wr_before;
    int errs = 0;
    logic [7:0] ws = 8'h00;
    logic [7:0] rs = 8'h00;
    for (int i = 0; i < n; i++) begin
      ws = ws + dat[i];
      rs = rs + stored(b, i, corrupt);
      stall_total += stl[i];
    end
    start = 1'b1; baseAddr = b; length = 9'(n); corrupt_req = corrupt;
    prev_ok = exp_ok; t_start = cyc; n_cur = n; base_cur = b;
    load_end = cyc + n + stall_total; done_cyc = load_end + n + 1;
    exp_ok = (ws == rs); wr_cnt = 0; wr_before = wr_seen;
    have_run = 1'b1;
    tick();
    start = 1'b0; baseAddr = 8'($urandom); length = 9'($urandom);
    for (int i = 0; i < n; i++) begin
      if (i == abort_at) begin
        in_reset = 1'b1; reset = 1'b1; inValid = 1'b0;
        #1;
        chk("rst_inReady", int'(inReady), 0);
        chk("rst_enables", int'({ramWriteEnable, ramReadEnable}), 0);
        chk("rst_addr", int'(ramAddr), 0);
        chk("rst_dataIn", int'(ramDataIn), 0);
        chk("rst_busyDone", int'({busy, done}), 0);
        chk("rst_verifyOk", int'(verifyOk), 0);
        tick(); tick();
        reset = 1'b0; in_reset = 1'b0; have_run = 1'b0; exp_ok = 1'b0; corrupt_req = 1'b0;
        return;
      end
      repeat (stl[i]) begin
        inValid = 1'b0; inData = 8'($urandom);
        tick();
      end
      inValid = 1'b1; inData = dat[i];
      tick();
    end
    inValid = 1'b0;
    while (cyc <= done_cyc) begin
      if (spur && cyc == load_end + 1) begin
        start = 1'b1; baseAddr = 8'h77; length = 9'd5;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0; corrupt_req = 1'b0;
    for (int i = 0; i < n; i++)
      if (ram[8'((int'(b) + i) % 256)] != stored(b, i, corrupt)) errs++;
    chk("ramImage", errs, 0);
    chk("writeCount", wr_seen - wr_before, n);
  endtask

  task automatic clear_stalls();
    for (int i = 0; i < 256; i++) stl[i] = 0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; baseAddr = 8'h00; length = 9'd0;
    inValid = 1'b0; inData = 8'h00;
    clear_stalls();
    #1;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Basic load.
    dat[0] = 8'h11; dat[1] = 8'h22; dat[2] = 8'h33; dat[3] = 8'h44;
    do_run(8'h10, 4, 1'b0, -1, 1'b0);
    chk("basic_done_T9", done_seen - t_start, 9);
    chk("basic_ok", int'(verifyOk), 1);
    chk("basic_ram10", int'(ram[8'h10]), 'h11);
    chk("basic_ram13", int'(ram[8'h13]), 'h44);

    // Address wrap.
    for (int i = 0; i < 4; i++) dat[i] = 8'(8'hA0 + i);
    do_run(8'hFE, 4, 1'b0, -1, 1'b0);
    chk("wrap_ramFE", int'(ram[8'hFE]), 'hA0);
    chk("wrap_ramFF", int'(ram[8'hFF]), 'hA1);
    chk("wrap_ram00", int'(ram[8'h00]), 'hA2);
    chk("wrap_ram01", int'(ram[8'h01]), 'hA3);
    chk("wrap_ok", int'(verifyOk), 1);

    // Backpressure: two idle cycles before the 2nd and 3rd byte.
    dat[0] = 8'h05; dat[1] = 8'h06; dat[2] = 8'h07;
    stl[1] = 2; stl[2] = 2;
    do_run(8'h30, 3, 1'b0, -1, 1'b0);
    chk("bp_done_T11", done_seen - t_start, 11);
    chk("bp_ok", int'(verifyOk), 1);
    clear_stalls();

    // Corruption between LOAD and VERIFY.
    dat[0] = 8'h11; dat[1] = 8'h22; dat[2] = 8'h33; dat[3] = 8'h44;
    do_run(8'h10, 4, 1'b1, -1, 1'b0);
    chk("corrupt_done_T9", done_seen - t_start, 9);
    chk("corrupt_ok", int'(verifyOk), 0);

    // Length 0.
    do_run(8'h55, 0, 1'b0, -1, 1'b0);
    chk("len0_done_T1", done_seen - t_start, 1);
    chk("len0_ok", int'(verifyOk), 1);

    // Full RAM, data = address.
    for (int i = 0; i < 256; i++) dat[i] = 8'(i);
    do_run(8'h00, 256, 1'b0, -1, 1'b0);
    chk("full_ramC3", int'(ram[8'hC3]), 'hC3);
    chk("full_ok", int'(verifyOk), 1);

    // Reset after the 2nd of 4 bytes, then a clean rerun.
    dat[0] = 8'h9A; dat[1] = 8'hBC; dat[2] = 8'hDE; dat[3] = 8'hF0;
    do_run(8'h40, 4, 1'b0, 2, 1'b0);
    chk("rst_ram40", int'(ram[8'h40]), 'h9A);
    chk("rst_ram41", int'(ram[8'h41]), 'hBC);
    chk("rst_ram42_unwritten", int'(ram[8'h42] == 8'hDE), 0);
    tick();
    do_run(8'h40, 4, 1'b0, -1, 1'b0);
    chk("rerun_ok", int'(verifyOk), 1);

    // Spurious start during VERIFY.
    do_run(8'h80, 4, 1'b0, -1, 1'b1);
    chk("spur_ok", int'(verifyOk), 1);

    // Randomized runs with random stalls and occasional spurious starts.
    for (int r = 0; r < 12; r++) begin
      int n;
      n = int'($urandom_range(1, 48));
      for (int i = 0; i < n; i++) begin
        dat[i] = 8'($urandom);
        stl[i] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
      end
      do_run(8'($urandom), n, 1'b0, -1, bit'($urandom_range(0, 1)));
      repeat (int'($urandom_range(0, 2))) tick();
    end
    clear_stalls();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ram_loader.md
# ram_loader

Bus-master front end for the 256x8 program/data RAM. It accepts a byte stream over a valid/ready handshake and writes it to consecutive RAM addresses starting at a programmable base. It then reads the same region back and compares an 8-bit modulo checksum of the read data against the checksum of the written data. It sits between the program-mode input path (switch/serial loader) and the RAM's `addr`/`dataIn`/`readEnable`/`writeEnable`/`dataOut` pins, and owns the RAM only while `busy` is high.

## Interface
Parameters:
- `ADDR_WIDTH`, default 8: RAM address width.
- `DATA_WIDTH`, default 8: RAM word width; also the checksum width.

Ports:
- `clk`, in, 1: single clock. All state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: begin a load. Sampled only in IDLE.
- `baseAddr`, in, ADDR_WIDTH: first RAM address. Captured on an accepted `start`.
- `length`, in, ADDR_WIDTH+1: byte count, 0..256. Captured on an accepted `start`.
- `inValid`, in, 1: `inData` is valid.
- `inData`, in, DATA_WIDTH: byte to be written.
- `inReady`, out, 1: loader accepts `inData`. Transfer occurs when `inValid` and `inReady` are both high.
- `ramAddr`, out, ADDR_WIDTH: drives RAM `addr`.
- `ramDataIn`, out, DATA_WIDTH: drives RAM `dataIn`.
- `ramWriteEnable`, out, 1: drives RAM `writeEnable`.
- `ramReadEnable`, out, 1: drives RAM `readEnable`.
- `ramDataOut`, in, DATA_WIDTH: from RAM `dataOut`. Combinational read.
- `busy`, out, 1: high in LOAD, VERIFY and DONE.
- `done`, out, 1: one-cycle pulse at the end of a run.
- `verifyOk`, out, 1: result of the last run. Sticky until the next accepted `start`.

## Operation
States are IDLE, LOAD, VERIFY and DONE.

- **IDLE**
  - `start` = 1 captures `baseAddr` into the pointer and `length` into the remaining-count register.
  - Both checksums clear to 0 and `verifyOk` clears.
  - Next state is LOAD, or DONE if `length` = 0.
- **LOAD**
  - `inReady` = 1.
  - `ramWriteEnable` = `inValid`, `ramDataIn` = `inData`, `ramAddr` = pointer. These are combinational, so the RAM writes on the same edge the handshake completes.
  - On each transfer: write checksum += `inData` (mod 2^DATA_WIDTH), pointer += 1 (wraps 0xFF→0x00), remaining −= 1.
  - When the last byte transfers, the pointer reloads from the captured base, remaining reloads from the captured length, and the next state is VERIFY.
  - `inValid` = 0 stalls the state with no write.
- **VERIFY**
  - `ramReadEnable` = 1, `ramAddr` = pointer, `inReady` = 0.
  - Each cycle: read checksum += `ramDataOut`, pointer += 1 with wrap, remaining −= 1.
  - After the last read the next state is DONE.
- **DONE**
  - `done` = 1 for exactly one cycle.
  - `verifyOk` is registered as (write checksum == read checksum). For `length` = 0, `verifyOk` = 1.
  - Next state is IDLE.

Rules and boundary conditions:
- `start` outside IDLE is ignored.
- `inData` presented outside LOAD is not accepted.
- `ramWriteEnable` and `ramReadEnable` are never high together.
- Both RAM enables are 0 outside LOAD and VERIFY. `ramAddr` = 0 when idle.
- The address region wraps modulo 2^ADDR_WIDTH. With `length` = 256, every location is written exactly once.
- On `reset`, asserted at any time:
  - State goes to IDLE and every output goes to 0 (`inReady`, RAM enables, `ramAddr`, `ramDataIn`, `busy`, `done`, `verifyOk`).
  - RAM contents already written are left as-is.
  - Partial-run results are discarded.

## Timing
- Load throughput is 1 byte/cycle while `inValid` is held. Verify is exactly N cycles.
- For N ≥ 1 bytes with no stalls, starting from the `start` edge T:
  - LOAD occupies cycles T+1..T+N.
  - VERIFY occupies T+N+1..T+2N.
  - `done` = 1 in cycle T+2N+1, and `verifyOk` is valid from that cycle.
  - `busy` falls in cycle T+2N+2.
- For `length` = 0, `done` pulses in cycle T+1.
- Input stalls extend LOAD one cycle per idle cycle. The verify length never changes.

## Structure
- Shared package `ram_loader_pkg` holds:
  - the state encoding (IDLE/LOAD/VERIFY/DONE);
  - default `ADDR_WIDTH`/`DATA_WIDTH` constants, shared with the RAM;
  - the RAM depth constant.
- One sub-module, `loader_addr_counter`, holds the wrapping pointer and the remaining counter. It has load, enable and last-item flag.
- The top level owns the FSM, both checksum registers and the output muxing.

## Test plan
- **Basic load:** base 0x10, length 4, bytes 0x11/0x22/0x33/0x44 back-to-back → RAM[0x10..0x13] holds those values, write sum 0xAA, `done` at T+9, `verifyOk` = 1.
- **Address wrap:** base 0xFE, length 4, bytes 0xA0..0xA3 → writes land at 0xFE, 0xFF, 0x00, 0x01, and `verifyOk` = 1.
- **Backpressure:** length 3 with `inValid` low for 2 cycles between bytes → exactly 3 writes, no write on stall cycles, and `done` arrives 4 cycles later than with no stalls.
- **Corruption:** the bench RAM model flips bit 0 of address 0x11 between LOAD and VERIFY → `done` pulses and `verifyOk` = 0.
- **Edge lengths:**
  - length 0 → no RAM enables, `done` at T+1, `verifyOk` = 1.
  - length 256, base 0, data = address → all 256 locations correct, `verifyOk` = 1.
- **Reset and spurious start:**
  - `reset` asserted after the 2nd of 4 bytes → all outputs 0 immediately, RAM[base], RAM[base+1] retained, and the next `start` runs cleanly.
  - `start` pulsed during VERIFY → ignored.
